// File: rtl/dma_mon_pkg.sv
// Shared definitions for the DMA protocol monitor.
//   - One-hot timing-control state constants (SI, SO, S1, S2, S3, S4).
//   - Error code enumeration and the number of distinct error codes.
//   - legal_transition(): checks one step of the timing state machine.
package dma_mon_pkg;

  localparam logic [5:0] ST_SI = 6'b000001;
  localparam logic [5:0] ST_SO = 6'b000010;
  localparam logic [5:0] ST_S1 = 6'b000100;
  localparam logic [5:0] ST_S2 = 6'b001000;
  localparam logic [5:0] ST_S3 = 6'b010000;
  localparam logic [5:0] ST_S4 = 6'b100000;

  localparam int NUM_ERR = 6;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_DACK_MULTI   = 3'd1,
    ERR_DACK_NO_REQ  = 3'd2,
    ERR_DACK_NO_HLDA = 3'd3,
    ERR_WRONG_PRIO   = 3'd4,
    ERR_TIMEOUT      = 3'd5,
    ERR_BAD_STATE    = 3'd6
  } err_code_e;

  // A non-one-hot previous state never has a legal successor, so a corrupt
  // state keeps flagging until the controller is back in a known state.
  function automatic logic legal_transition(input logic [5:0] prev, input logic [5:0] nxt);
    logic ok;
    ok = 1'b0;
    case (prev)
      ST_SI:   ok = (nxt == ST_SI) || (nxt == ST_SO);
      ST_SO:   ok = (nxt == ST_SO) || (nxt == ST_S1) || (nxt == ST_SI);
      ST_S1:   ok = (nxt == ST_S2);
      ST_S2:   ok = (nxt == ST_S3) || (nxt == ST_S4);
      ST_S3:   ok = (nxt == ST_S3) || (nxt == ST_S4);
      ST_S4:   ok = (nxt == ST_SI) || (nxt == ST_S1);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dma_mon_prio_model.sv
// Priority order model for the DMA protocol monitor.
// Keeps the index of the currently highest-priority channel; the full order
// is that channel followed by the others in ascending, wrapping sequence.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   rotating_i          1 = rotating priority, 0 = fixed (ch0 highest)
//   release_valid_i     a channel released its DACK this cycle
//   release_ch_i        released channel index
//   req_i               request vector to arbitrate
//   top_ch_o            highest-priority set bit of req_i under current order
//   top_valid_o         req_i has at least one bit set
module dma_mon_prio_model #(
  parameter int NCH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    rotating_i,
  input  logic                    release_valid_i,
  input  logic [$clog2(NCH)-1:0]  release_ch_i,
  input  logic [NCH-1:0]          req_i,
  output logic [$clog2(NCH)-1:0]  top_ch_o,
  output logic                    top_valid_o
);

  localparam int CH_W = $clog2(NCH);

  logic [CH_W-1:0] hi_q, hi_d;
  logic [CH_W-1:0] order_ch [NCH];

  // The order register only changes on the edge after a release, so a grant
  // coinciding with a release is judged against the old order.
  always_comb begin
    hi_d = hi_q;
    if (!rotating_i) begin
      hi_d = '0;
    end else if (release_valid_i) begin
      hi_d = (release_ch_i == CH_W'(NCH - 1)) ? '0 : release_ch_i + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q <= '0;
    end else begin
      hi_q <= hi_d;
    end
  end

  // order_ch[k] = (hi_q + k) mod NCH, the channel holding priority rank k.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_order
    logic [CH_W:0] sum;
    assign sum = {1'b0, hi_q} + (CH_W+1)'(gi);
    assign order_ch[gi] = (sum >= (CH_W+1)'(NCH)) ? CH_W'(sum - (CH_W+1)'(NCH))
                                                  : sum[CH_W-1:0];
  end

  // Scan from lowest rank upwards so the best-ranked requester wins.
  always_comb begin
    top_ch_o    = '0;
    top_valid_o = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req_i[order_ch[k]]) begin
        top_ch_o    = order_ch[k];
        top_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_protocol_monitor.sv
// Passive protocol monitor for the DMA controller bus interface.
// Samples DREQ/DACK/HLDA and the one-hot timing state, flags protocol
// violations one cycle after the offending sample, and accumulates sticky
// error flags, a saturating error-cycle counter and per-channel grant coverage.
// Ports:
//   CLK, RESET_N      clock, asynchronous active-low reset
//   CS_N              checks gated while high (history still tracked)
//   HLDA              hold acknowledge
//   DREQ, DACK        channel requests / acknowledges
//   ROTATING          priority mode (0 fixed, 1 rotating)
//   STATE             one-hot timing-control state
//   CLR               clears sticky flags, counter, coverage
//   ERR_VALID/CODE/CH registered report of the lowest error code this cycle
//   ERR_STICKY        bit k-1 set once code k occurred
//   ERR_COUNT         saturating count of error cycles
//   COV_DACK          channels granted at least once
module dma_protocol_monitor
  import dma_mon_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int MAX_LATENCY = 16,
  parameter int CNT_W       = 8,
  parameter int STATE_W     = 6
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    CS_N,
  input  logic                    HLDA,
  input  logic [NCH-1:0]          DREQ,
  input  logic [NCH-1:0]          DACK,
  input  logic                    ROTATING,
  input  logic [STATE_W-1:0]      STATE,
  input  logic                    CLR,
  output logic                    ERR_VALID,
  output logic [2:0]              ERR_CODE,
  output logic [$clog2(NCH)-1:0]  ERR_CH,
  output logic [5:0]              ERR_STICKY,
  output logic [CNT_W-1:0]        ERR_COUNT,
  output logic [NCH-1:0]          COV_DACK
);

  localparam int CH_W  = $clog2(NCH);
  localparam int LAT_W = $clog2(MAX_LATENCY + 1);

  logic [NCH-1:0]     dreq_q, dack_q;
  logic [STATE_W-1:0] state_q;
  logic               first_q;

  logic               err_valid_q;
  err_code_e          err_code_q, err_code_d;
  logic [CH_W-1:0]    err_ch_q, err_ch_d;
  logic [NUM_ERR-1:0] err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic [NCH-1:0]     cov_q, cov_d;

  logic [NCH-1:0]     tmo;
  logic [CH_W-1:0]    grant_ch, release_ch, tmo_ch, top_ch;
  logic               grant, release_any, top_valid;
  logic [NUM_ERR-1:0] err_raw, err_v;

  // Per-channel waiting-time counters. The hit flag marks the single cycle
  // in which the counter steps onto MAX_LATENCY; once saturated it stays
  // silent until the request drops or is acknowledged.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_lat
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic             hit;

    always_comb begin
      cnt_d = cnt_q;
      hit   = 1'b0;
      if (!DREQ[gi] || DACK[gi]) begin
        cnt_d = '0;
      end else if (HLDA && (DACK == '0) && !CS_N && (cnt_q != LAT_W'(MAX_LATENCY))) begin
        cnt_d = cnt_q + 1'b1;
        hit   = (cnt_q == LAT_W'(MAX_LATENCY - 1));
      end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign tmo[gi] = hit;
  end

  // With several bits set (already a DACK_MULTI error) the lowest one stands
  // for the grant or release.
  always_comb begin
    grant_ch   = '0;
    release_ch = '0;
    tmo_ch     = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (DACK[i])                begin grant_ch   = CH_W'(i); end
      if (dack_q[i] && !DACK[i])  begin release_ch = CH_W'(i); end
      if (tmo[i])                 begin tmo_ch     = CH_W'(i); end
    end
  end

  assign grant       = (dack_q == '0) && (DACK != '0);
  assign release_any = (dack_q & ~DACK) != '0;

  dma_mon_prio_model #(
    .NCH (NCH)
  ) u_prio (
    .clk_i           (CLK),
    .rst_ni          (RESET_N),
    .rotating_i      (ROTATING),
    .release_valid_i (release_any),
    .release_ch_i    (release_ch),
    .req_i           (dreq_q),
    .top_ch_o        (top_ch),
    .top_valid_o     (top_valid)
  );

  // err_raw[k-1] corresponds to error code k.
  always_comb begin
    err_raw    = '0;
    err_raw[0] = (DACK & (DACK - 1'b1)) != '0;
    err_raw[1] = grant && !dreq_q[grant_ch];
    err_raw[2] = (DACK != '0) && !HLDA;
    err_raw[3] = grant && top_valid && (top_ch != grant_ch);
    err_raw[4] = |tmo;
    // Leaving reset the controller may be anywhere, so any jump into SI is
    // accepted on that first cycle.
    err_raw[5] = !$onehot(STATE) ||
                 !(legal_transition(state_q, STATE) || (first_q && (STATE == STATE_W'(ST_SI))));
  end

  assign err_v = CS_N ? '0 : err_raw;

  always_comb begin
    err_code_d = ERR_NONE;
    for (int i = NUM_ERR - 1; i >= 0; i--) begin
      if (err_v[i]) begin
        err_code_d = err_code_e'(3'(i + 1));
      end
    end
    case (err_code_d)
      ERR_DACK_NO_REQ, ERR_WRONG_PRIO: err_ch_d = grant_ch;
      ERR_TIMEOUT:                     err_ch_d = tmo_ch;
      default:                         err_ch_d = '0;
    endcase
  end

  // A clear in the same cycle as a new error keeps that error's contribution.
  always_comb begin
    err_sticky_d = (CLR ? '0 : err_sticky_q) | err_v;
    cov_d        = (CLR ? '0 : cov_q) | ((grant && !CS_N) ? DACK : '0);
    err_count_d  = CLR ? '0 : err_count_q;
    if ((err_v != '0) && (err_count_d != {CNT_W{1'b1}})) begin
      err_count_d = err_count_d + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      dreq_q       <= '0;
      dack_q       <= '0;
      state_q      <= STATE_W'(ST_SI);
      first_q      <= 1'b1;
      err_valid_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      err_ch_q     <= '0;
      err_sticky_q <= '0;
      err_count_q  <= '0;
      cov_q        <= '0;
    end else begin
      dreq_q       <= DREQ;
      dack_q       <= DACK;
      state_q      <= STATE;
      first_q      <= 1'b0;
      err_valid_q  <= (err_v != '0);
      err_code_q   <= err_code_d;
      err_ch_q     <= err_ch_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
      cov_q        <= cov_d;
    end
  end

  assign ERR_VALID  = err_valid_q;
  assign ERR_CODE   = err_code_q;
  assign ERR_CH     = err_ch_q;
  assign ERR_STICKY = err_sticky_q;
  assign ERR_COUNT  = err_count_q;
  assign COV_DACK   = cov_q;

endmodule

// File: tb/tb_dma_protocol_monitor.sv
module tb_dma_protocol_monitor;

  localparam int NCH  = 4;
  localparam int MAXL = 16;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       CS_N = 1'b1;
  logic       HLDA = 1'b0;
  logic       ROTATING = 1'b0;
  logic       CLR = 1'b0;
  logic [3:0] DREQ = '0;
  logic [3:0] DACK = '0;
  logic [5:0] STATE = 6'b000001;

  logic       ERR_VALID, ERR_VALID2;
  logic [2:0] ERR_CODE, ERR_CODE2;
  logic [1:0] ERR_CH, ERR_CH2;
  logic [5:0] ERR_STICKY, ERR_STICKY2;
  logic [7:0] ERR_COUNT;
  logic [1:0] ERR_COUNT2;
  logic [3:0] COV_DACK, COV_DACK2;

  dma_protocol_monitor #(.NCH(4), .MAX_LATENCY(16), .CNT_W(8), .STATE_W(6)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CS_N(CS_N), .HLDA(HLDA), .DREQ(DREQ), .DACK(DACK),
    .ROTATING(ROTATING), .STATE(STATE), .CLR(CLR), .ERR_VALID(ERR_VALID), .ERR_CODE(ERR_CODE),
    .ERR_CH(ERR_CH), .ERR_STICKY(ERR_STICKY), .ERR_COUNT(ERR_COUNT), .COV_DACK(COV_DACK));

  dma_protocol_monitor #(.NCH(4), .MAX_LATENCY(16), .CNT_W(2), .STATE_W(6)) dut_c2 (
    .CLK(CLK), .RESET_N(RESET_N), .CS_N(CS_N), .HLDA(HLDA), .DREQ(DREQ), .DACK(DACK),
    .ROTATING(ROTATING), .STATE(STATE), .CLR(CLR), .ERR_VALID(ERR_VALID2), .ERR_CODE(ERR_CODE2),
    .ERR_CH(ERR_CH2), .ERR_STICKY(ERR_STICKY2), .ERR_COUNT(ERR_COUNT2), .COV_DACK(COV_DACK2));

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: plain history, an explicit channel order list and
  // integer waiting times.
  bit         legal [6][6];
  logic [3:0] m_dreq, m_dack;
  logic [5:0] m_state;
  bit         m_first;
  int         m_order [NCH];
  int         m_lat [NCH];
  bit         e_valid;
  int         e_code, e_ch, e_count, e_count2;
  logic [5:0] e_sticky;
  logic [3:0] e_cov;

  function automatic int oh_idx(input logic [5:0] s);
    if ($countones(s) != 1) return -1;
    for (int i = 0; i < 6; i++) if (s[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_dreq = '0; m_dack = '0; m_state = 6'b000001; m_first = 1'b1;
    for (int k = 0; k < NCH; k++) begin m_order[k] = k; m_lat[k] = 0; end
    e_valid = 1'b0; e_code = 0; e_ch = 0; e_count = 0; e_count2 = 0;
    e_sticky = '0; e_cov = '0;
  endtask

  task automatic model_step();
    logic [6:1] e;
    int  tch, g, rel, top, p, n;
    bit  grant;
    e = '0; tch = -1; g = 0; rel = -1; top = -1;
    for (int i = 0; i < NCH; i++) begin
      if (!DREQ[i] || DACK[i]) m_lat[i] = 0;
      else if (HLDA && DACK == 0 && !CS_N && m_lat[i] < MAXL) begin
        m_lat[i]++;
        if (m_lat[i] == MAXL && tch < 0) tch = i;
      end
    end
    for (int i = NCH - 1; i >= 0; i--) if (DACK[i]) g = i;
    grant = (m_dack == 0) && (DACK != 0);
    if (!CS_N) begin
      if ($countones(DACK) > 1) e[1] = 1'b1;
      if (grant && !m_dreq[g]) e[2] = 1'b1;
      if (DACK != 0 && !HLDA) e[3] = 1'b1;
      if (grant) begin
        for (int k = 0; k < NCH; k++) if (top < 0 && m_dreq[m_order[k]]) top = m_order[k];
        if (top >= 0 && top != g) e[4] = 1'b1;
      end
      if (tch >= 0) e[5] = 1'b1;
      p = oh_idx(m_state);
      n = oh_idx(STATE);
      if (n < 0) e[6] = 1'b1;
      else if (!(m_first && n == 0) && !(p >= 0 && legal[p][n])) e[6] = 1'b1;
    end
    e_code = 0;
    for (int k = 6; k >= 1; k--) if (e[k]) e_code = k;
    e_valid = (e != 0);
    e_ch = (e_code == 2 || e_code == 4) ? g : (e_code == 5) ? tch : 0;
    e_sticky = (CLR ? 6'b0 : e_sticky) | e;
    e_count  = CLR ? 0 : e_count;
    e_count2 = CLR ? 0 : e_count2;
    if (e_valid && e_count < 255) e_count++;
    if (e_valid && e_count2 < 3) e_count2++;
    e_cov = (CLR ? 4'b0 : e_cov) | ((!CS_N && grant) ? DACK : 4'b0);
    for (int i = NCH - 1; i >= 0; i--) if (m_dack[i] && !DACK[i]) rel = i;
    if (!ROTATING) begin
      for (int k = 0; k < NCH; k++) m_order[k] = k;
    end else if (rel >= 0) begin
      for (int k = 0; k < NCH; k++) m_order[k] = (rel + 1 + k) % NCH;
    end
    m_dreq = DREQ; m_dack = DACK; m_state = STATE; m_first = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("valid",  ERR_VALID,  e_valid);
    chk("code",   ERR_CODE,   e_code);
    chk("ch",     ERR_CH,     e_ch);
    chk("sticky", ERR_STICKY, e_sticky);
    chk("count",  ERR_COUNT,  e_count);
    chk("cov",    COV_DACK,   e_cov);
    chk("count2", ERR_COUNT2, e_count2);
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    cyc++;
    $display("cyc=%0d cs_n=%b hlda=%b rot=%b dreq=%b dack=%b state=%b clr=%b -> v=%b code=%0d ch=%0d cnt=%0d cov=%b",
             cyc, CS_N, HLDA, ROTATING, DREQ, DACK, STATE, CLR, ERR_VALID, ERR_CODE, ERR_CH, ERR_COUNT, COV_DACK);
    chk_all();
  endtask

  initial begin
    int nv, at, cd, cn, p, nc, r, ch;
    int cand [6];

    legal[0][0] = 1; legal[0][1] = 1; legal[1][1] = 1; legal[1][2] = 1; legal[1][0] = 1;
    legal[2][3] = 1; legal[3][4] = 1; legal[3][5] = 1; legal[4][4] = 1; legal[4][5] = 1;
    legal[5][0] = 1; legal[5][2] = 1;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    chk_all();
    RESET_N = 1'b1; CS_N = 1'b0; HLDA = 1'b1;

    // Fixed mode, legal grant of ch1 among {1,2}
    DREQ = 4'b0110; tick();
    DACK = 4'b0010; tick();
    chk("fix_ok_valid", ERR_VALID, 0);
    chk("fix_ok_cov", COV_DACK, 4'b0010);
    chk("fix_ok_count", ERR_COUNT, 0);
    DACK = 4'b0000; DREQ = 4'b0000; tick();

    // Fixed mode, ch1 granted while ch0 requests -> WRONG_PRIO on ch1
    DREQ = 4'b0011; tick();
    DACK = 4'b0010; tick();
    chk("fix_prio_valid", ERR_VALID, 1);
    chk("fix_prio_code", ERR_CODE, 4);
    chk("fix_prio_ch", ERR_CH, 1);
    chk("fix_prio_sticky3", ERR_STICKY[3], 1);
    DACK = 4'b0000; DREQ = 4'b0000; tick();

    // Rotating mode: after ch1 is released ch2 is highest
    ROTATING = 1'b1;
    DREQ = 4'b0010; tick();
    DACK = 4'b0010; tick();
    DACK = 4'b0000; tick();
    DREQ = 4'b0101; tick();
    DACK = 4'b0100; tick();
    chk("rot_ok_valid", ERR_VALID, 0);
    DACK = 4'b0000; DREQ = 4'b0010; tick();
    DACK = 4'b0010; tick();
    DACK = 4'b0000; tick();
    DREQ = 4'b0101; tick();
    DACK = 4'b0001; tick();
    chk("rot_bad_code", ERR_CODE, 4);
    chk("rot_bad_ch", ERR_CH, 0);
    DACK = 4'b0000; DREQ = 4'b0000; ROTATING = 1'b0; tick();
    tick();

    // Timeout: ch3 waits 20 cycles, exactly one report after 16 increments
    CLR = 1'b1; tick();
    CLR = 1'b0; DREQ = 4'b1000;
    nv = 0; at = 0; cd = 0; cn = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (ERR_VALID) begin nv++; at = c; cd = ERR_CODE; cn = ERR_CH; end
    end
    chk("tmo_pulses", nv, 1);
    chk("tmo_when", at, 16);
    chk("tmo_code", cd, 5);
    chk("tmo_ch", cn, 3);
    chk("tmo_count", ERR_COUNT, 1);
    DREQ = 4'b0000; tick();

    // Double DACK together with an illegal SI->S2 jump
    DREQ = 4'b0011; tick();
    DACK = 4'b0011; STATE = 6'b001000; tick();
    chk("multi_code", ERR_CODE, 1);
    chk("multi_ch", ERR_CH, 0);
    chk("multi_sticky0", ERR_STICKY[0], 1);
    chk("multi_sticky5", ERR_STICKY[5], 1);
    chk("multi_count", ERR_COUNT, 2);
    DACK = 4'b0000; DREQ = 4'b0000; STATE = 6'b010000; tick();
    STATE = 6'b100000; tick();
    STATE = 6'b000001; tick();

    // Saturation of the 2-bit counter
    CLR = 1'b1; tick();
    CLR = 1'b0; STATE = 6'b000011;
    repeat (5) tick();
    chk("sat_count8", ERR_COUNT, 5);
    chk("sat_count2", ERR_COUNT2, 3);
    STATE = 6'b000001; tick();

    // Clear coinciding with an error: error wins
    CLR = 1'b1; STATE = 6'b000000; tick();
    chk("clr_err_count", ERR_COUNT, 1);
    chk("clr_err_count2", ERR_COUNT2, 1);
    chk("clr_err_sticky", ERR_STICKY, 6'b100000);
    CLR = 1'b0; STATE = 6'b000001; tick();
    tick();

    // Asynchronous reset mid-cycle
    RESET_N = 1'b0;
    #2;
    model_reset();
    chk_all();
    chk("arst_count", ERR_COUNT, 0);
    chk("arst_sticky", ERR_STICKY, 0);
    #2;
    RESET_N = 1'b1;
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 500; c++) begin
      bit quiet;
      quiet = (c % 100) < 25;
      if ($urandom_range(0, 3) == 0) DREQ = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 9);
      if (quiet) DACK = 4'b0000;
      else if (DACK != 0 && r < 5) DACK = DACK;
      else if (r < 4) DACK = 4'b0000;
      else if (r < 9) begin ch = $urandom_range(0, 3); DACK = 4'(1 << ch); end
      else DACK = 4'($urandom_range(0, 15));
      HLDA = ($urandom_range(0, 9) != 0);
      CS_N = ($urandom_range(0, 9) == 0);
      CLR  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 19) == 0) ROTATING = ~ROTATING;
      p = oh_idx(STATE);
      if ($urandom_range(0, 19) == 0) STATE = 6'($urandom_range(0, 63));
      else if (p < 0) STATE = 6'b000001;
      else begin
        nc = 0;
        for (int n = 0; n < 6; n++) if (legal[p][n]) begin cand[nc] = n; nc++; end
        STATE = 6'(1 << cand[$urandom_range(0, nc - 1)]);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
